// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared constants and FSM state type for the MIPS memory controller.
package mips_mem_pkg;
  localparam int WORD_W = 32;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_WAIT_CYCLES = 2;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bus between the datapath (master) and mem_ctrl (slave).
interface mem_ctrl_if;
  import mips_mem_pkg::*;
  logic mem_read;
  logic mem_write;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic ready;
  logic err;
  modport master(output mem_read, mem_write, addr, wdata, input rdata, ready, err);
  modport slave(input mem_read, mem_write, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32 word storage, one synchronous port with registered read data.
module mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic                     we,
  input  logic                     re,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q, rdata_d;
  assign rdata_d = re ? mem[idx] : rdata_q;
  assign rdata = rdata_q;
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata_q <= '0;
    else rdata_q <= rdata_d;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: multi-cycle unified memory controller with WAIT_CYCLES wait states and a one-cycle ready pulse.
// Define MEM_CTRL_ALIGN_CHECK_EN to flag (and suppress) accesses with addr[1:0] != 0.
module mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic        clk,
  input logic        rst,
  mem_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic wr_q, wr_d, mis_q, mis_d;
  logic ready_q, err_q;
  logic req, mis_in, go, we, re;
  logic unused_addr;
  assign req = bus.mem_read | bus.mem_write;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign mis_in = |bus.addr[1:0];
`else
  assign mis_in = 1'b0;
`endif
  assign unused_addr = ^{bus.addr[WORD_W-1:AW+2], bus.addr[1:0]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    mis_d = mis_q;
    if (state_q == IDLE && req) begin
      idx_d = bus.addr[AW+1:2];
      wdata_d = bus.wdata;
      wr_d = bus.mem_write;
      mis_d = mis_in;
      cnt_d = 4'(WAIT_CYCLES);
      state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? DONE : WAIT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // the *_d capture values are the live inputs when a zero-wait access goes straight to DONE
  assign go = (state_d == DONE) && (state_q != DONE);
  assign we = go & wr_d & ~mis_d & ~rst;
  assign re = go & ~wr_d & ~mis_d & ~rst;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      mis_q <= 1'b0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      mis_q <= mis_d;
      ready_q <= go;
      err_q <= go & mis_d;
    end
  mem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .rst(rst),
    .idx(idx_d),
    .we(we),
    .re(re),
    .wdata(wdata_d),
    .rdata(bus.rdata)
  );
  assign bus.ready = ready_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven and randomized checks of mem_ctrl against a word-array reference model.
module tb_mem_ctrl;
  localparam int W = 2;
  localparam int D = 1024;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [D];
  logic [31:0] ref_rdata;
  always #5 clk = ~clk;
  mem_ctrl_if bus();
  mem_ctrl_if bus0();
  mem_ctrl #(.DEPTH(D), .WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  mem_ctrl #(.DEPTH(D), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] er, output logic ee);
    int idx;
    logic mis;
    idx = int'((a >> 2) % D);
    mis = ALIGN && (a % 4 != 0);
    ee = mis;
    if (!mis) begin
      if (wr) ref_mem[idx] = d;
      else if (rd) ref_rdata = ref_mem[idx];
    end
    er = ref_rdata;
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    @(negedge clk);
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr = $urandom;
    bus.wdata = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.ready && lat < 40);
    chk({tag, " latency"}, 32'(lat), 32'(W));
    chk({tag, " rdata"}, bus.rdata, exp_rd);
    chk({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, {31'd0, bus.ready}, 32'd0);
  endtask

  initial begin
    vec_t vt[10];
    logic [31:0] er;
    logic ee;
    vt[0] = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vt[1] = '{1'b1, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'h20,   32'h12345678, 32'hDEADBEEF, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h20,   32'h0,        32'h12345678, 1'b0};
    vt[4] = '{1'b0, 1'b1, 32'h1004, 32'hA5A5A5A5, 32'h12345678, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h0004, 32'h0,        32'hA5A5A5A5, 1'b0};
    vt[6] = '{1'b1, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vt[7] = '{1'b1, 1'b0, 32'h6,    32'h0,        ALIGN ? 32'hDEADBEEF : 32'hA5A5A5A5, ALIGN};
    vt[8] = '{1'b0, 1'b1, 32'h8,    32'h0,        ALIGN ? 32'hDEADBEEF : 32'hA5A5A5A5, 1'b0};
    vt[9] = '{1'b1, 1'b0, 32'h8,    32'hFFFFFFFF, 32'h0,        1'b0};
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus0.mem_read = 1'b0;
    bus0.mem_write = 1'b0;
    bus0.addr = '0;
    bus0.wdata = '0;
    ref_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, bus.ready}, 32'd0);
    chk("reset err", {31'd0, bus.err}, 32'd0);
    chk("reset rdata", bus.rdata, 32'd0);
    chk("reset ready w0", {31'd0, bus0.ready}, 32'd0);
    chk("reset rdata w0", bus0.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      model(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, er, ee);
      access(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].exp_rdata, vt[i].exp_err, $sformatf("vec%0d", i));
    end
    // reset during the WAIT of a write must discard it
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.addr = 32'h8;
    bus.wdata = 32'h1;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst ready", {31'd0, bus.ready}, 32'd0);
    chk("midrst rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("midrst quiet", {31'd0, bus.ready}, 32'd0);
    end
    model(1'b1, 1'b0, 32'h8, 32'h0, er, ee);
    access(1'b1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, "midrst read");
    // zero wait states with the request held: ready every second cycle
    @(negedge clk);
    bus0.mem_read = 1'b1;
    bus0.mem_write = 1'b1;
    bus0.addr = 32'h40;
    bus0.wdata = 32'h55AA55AA;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w0 ready[%0d]", i), {31'd0, bus0.ready}, {31'd0, (i % 2 == 0)});
    end
    @(negedge clk);
    bus0.mem_read = 1'b0;
    bus0.mem_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, d;
      a = 32'(i) << 2;
      d = $urandom;
      model(1'b0, 1'b1, a, d, er, ee);
      access(1'b0, 1'b1, a, d, er, ee, $sformatf("init%0d", i));
    end
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, d;
      int kind;
      kind = $urandom_range(0, 2);
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      model(kind != 1, kind != 0, a, d, er, ee);
      access(kind != 1, kind != 0, a, d, er, ee, $sformatf("rnd%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Unified instruction/data memory controller for the multi-cycle MIPS core. It accepts the datapath's MemRead/MemWrite requests, which carry the address already muxed by IorD. It models a single-ported word memory with a configurable number of wait states and returns read data with a one-cycle `ready` pulse. The controller FSM stalls in its fetch/load/store states until `ready` is seen.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: extra wait states per access; 0..15 legal.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_read`  in  1  read request (datapath MemRead).
- `mem_write`  in  1  write request (datapath MemWrite).
- `addr`  in  32  byte address from the IorD mux.
- `wdata`  in  32  store data (datapath B register).
- `rdata`  out  32  read data; holds its value until the next successful read completes.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  misalignment flag; valid only while `ready`=1.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - If `mem_write`|`mem_read` is high at an edge, capture `addr`, `wdata` and the op.
  - If both are high, the op is a write and the read is dropped.
  - Load counter with `WAIT_CYCLES`.
  - Go to WAIT, or go straight to DONE when `WAIT_CYCLES`=0.
- WAIT: decrement counter each edge. When the counter is 1 at an edge, go to DONE.
- Entering DONE, on the same edge:
  - Read: `rdata` <= mem[word_idx].
  - Write: mem[word_idx] <= captured `wdata`.
- DONE: `ready`=1 for exactly one cycle, then unconditionally return to IDLE. The mandatory idle cycle prevents the still-asserted request from retriggering.
- `word_idx` = `addr`[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH×4.
- Requests are committed at capture. Dropping `mem_read`/`mem_write` during WAIT does not abort the access. Changes to `addr`/`wdata` after capture are ignored.
- Memory contents are not cleared by reset. `rdata` is unchanged by writes.

## Timing
- Reset values: state IDLE, counter 0, `ready`=0, `err`=0, `rdata`=0.
- Reset asserted mid-access discards the access. A pending write is not performed.
- Request sampled at edge k → `ready` high in the cycle after edge k+`WAIT_CYCLES`. The access occupies `WAIT_CYCLES`+1 cycles.
- Earliest next capture is at edge k+`WAIT_CYCLES`+2. Throughput is 1 access per `WAIT_CYCLES`+2 cycles.
- `ready` and `err` are registered outputs. `rdata` is valid in the `ready` cycle and stays stable afterwards.

## Configuration
- `MEM_CTRL_ALIGN_CHECK_EN` defined:
  - When `addr`[1:0]≠0 at capture, no memory access is made and `rdata` is unchanged.
  - Timing is normal; `ready`=1 with `err`=1 in the DONE cycle.
- `MEM_CTRL_ALIGN_CHECK_EN` undefined:
  - `addr`[1:0] is ignored.
  - `err` is tied to 0.

## Structure
- Shared package `mips_mem_pkg`: state enum (IDLE/WAIT/DONE), `WORD_W`=32, default `DEPTH`/`WAIT_CYCLES` constants.
- One sub-module, `mem_array`: DEPTH×32 storage with one synchronous read/write port. It takes index, we, re and wdata, and its read output is registered.
- The FSM, counter and capture registers live in `mem_ctrl`.

## Test plan
- Reset with `WAIT_CYCLES`=2 → `ready`=0, `err`=0, `rdata`=0; a write of 0xDEADBEEF to 0x10, then a read of 0x10 → `ready` 3 cycles after each capture, `rdata`=0xDEADBEEF.
- `WAIT_CYCLES`=0, requests held high continuously → `ready` pulses every 2nd cycle and never for 2 consecutive cycles.
- `mem_read`=`mem_write`=1, addr 0x20, wdata 0x12345678 → write performed and `rdata` unchanged; a following read of 0x20 returns 0x12345678.
- DEPTH=1024: write 0xA5A5A5A5 to 0x1004, read 0x0004 → 0xA5A5A5A5 (wrap-around).
- `rst` raised in the WAIT cycle of a write of 0x1 to 0x8 (mem[2] previously 0x0) → state IDLE and `ready`=0 next cycle; a later read of 0x8 returns 0x0.
- With `MEM_CTRL_ALIGN_CHECK_EN`: read of 0x6 → `ready`=1 with `err`=1 and `rdata` held. Without the macro: the same read returns mem[1] with `err`=0.
